// File: rtl/ddr_cmd_arb_if.sv
// Bundle of requester-side and engine-side signals of the DDR command arbiter.
// The arbiter connects through the master modport and its environment through the slave modport.
interface ddr_cmd_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 64
);
    logic [1:0]              wr_req;
    logic [2*ADDR_WIDTH-1:0] wr_addr;
    logic [2*LEN_WIDTH-1:0]  wr_len;
    logic [1:0]              wr_gnt;
    logic [1:0]              wr_own;
    logic [1:0]              wr_dvld;
    logic [2*DATA_WIDTH-1:0] wr_data;
    logic [1:0]              rd_req;
    logic [2*ADDR_WIDTH-1:0] rd_addr;
    logic [2*LEN_WIDTH-1:0]  rd_len;
    logic [1:0]              rd_gnt;
    logic [1:0]              rd_own;
    logic [1:0]              rd_dvld;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    wstart;
    logic                    wready;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [LEN_WIDTH-1:0]    wdata_len;
    logic                    wdata_vld;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rstart;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [LEN_WIDTH-1:0]    rdata_len;
    logic                    rdata_vld;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    wr_timeout;
    logic                    rd_timeout;

    modport master (
        input  wr_req, wr_addr, wr_len, wr_dvld, wr_data,
        output wr_gnt, wr_own,
        input  rd_req, rd_addr, rd_len,
        output rd_gnt, rd_own, rd_dvld, rd_data,
        output wstart, waddr, wdata_len, wdata_vld, wdata,
        input  wready,
        output rstart, raddr, rdata_len,
        input  rready, rdata_vld, rdata,
        output wr_timeout, rd_timeout
    );

    modport slave (
        output wr_req, wr_addr, wr_len, wr_dvld, wr_data,
        input  wr_gnt, wr_own,
        output rd_req, rd_addr, rd_len,
        input  rd_gnt, rd_own, rd_dvld, rd_data,
        input  wstart, waddr, wdata_len, wdata_vld, wdata,
        output wready,
        input  rstart, raddr, rdata_len,
        output rready, rdata_vld, rdata,
        input  wr_timeout, rd_timeout
    );
endinterface

// File: rtl/ddr_cmd_arb.sv
// Two-requester DDR command arbiter: independent round-robin write and read paths feeding the engines.
// Optional watchdog per path is compiled in with `define DDR_ARB_TIMEOUT_EN.
module ddr_cmd_arb_path #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*LEN_WIDTH-1:0]  req_len,
    input  logic                    ready,
    output logic [1:0]              gnt,
    output logic [1:0]              own,
    output logic                    start,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [LEN_WIDTH-1:0]    len,
    output logic                    timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, BUSY} state_t;

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            own_q, own_d;
    logic                  start_q, start_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  last_q, last_d;
    logic                  guard_q, guard_d;
    logic [1:0]            len_zero;
    logic [1:0]            eligible;
    logic                  win;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    // Zero-length requests need no engine, so they stay eligible while the engine is busy.
    assign len_zero[0] = (req_len[LEN_WIDTH-1:0] == '0);
    assign len_zero[1] = (req_len[2*LEN_WIDTH-1:LEN_WIDTH] == '0);
    assign eligible    = req & (len_zero | {2{ready}});
    assign win         = (eligible == 2'b11) ? ~last_q : eligible[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        own_d   = own_q;
        start_d = 1'b0;
        addr_d  = addr_q;
        len_d   = len_q;
        last_d  = last_q;
        guard_d = guard_q;
`ifdef DDR_ARB_TIMEOUT_EN
        cnt_d     = '0;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    gnt_d[win] = 1'b1;
                    last_d     = win;
                    if (!len_zero[win]) begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                        own_d   = win ? 2'b10 : 2'b01;
                        addr_d  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                        len_d   = win ? req_len[2*LEN_WIDTH-1:LEN_WIDTH] : req_len[LEN_WIDTH-1:0];
                    end
                end
            end
            ISSUE: begin
                state_d = GUARD;
                guard_d = 1'b0;
            end
            GUARD: begin
                guard_d = 1'b1;
                if (guard_q) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ready) begin
                    state_d = IDLE;
                    own_d   = '0;
                end
            end
        endcase
`ifdef DDR_ARB_TIMEOUT_EN
        // A normal completion in the same cycle wins over the watchdog.
        if (state_q == GUARD || state_q == BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!(state_q == BUSY && ready) && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d   = IDLE;
                own_d     = '0;
                timeout_d = 1'b1;
                cnt_d     = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            own_q     <= '0;
            start_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            last_q    <= 1'b1;
            guard_q   <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            own_q     <= own_d;
            start_q   <= start_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            last_q    <= last_d;
            guard_q   <= guard_d;
`ifdef DDR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign own   = own_q;
    assign start = start_q;
    assign addr  = addr_q;
    assign len   = len_q;
`ifdef DDR_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
endmodule

module ddr_cmd_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 65535
) (
    input logic           clk,
    input logic           rst,
    ddr_cmd_arb_if.master bus
);
    ddr_cmd_arb_path #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_wr_path (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.wr_req),
        .req_addr(bus.wr_addr),
        .req_len (bus.wr_len),
        .ready   (bus.wready),
        .gnt     (bus.wr_gnt),
        .own     (bus.wr_own),
        .start   (bus.wstart),
        .addr    (bus.waddr),
        .len     (bus.wdata_len),
        .timeout (bus.wr_timeout)
    );

    ddr_cmd_arb_path #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_rd_path (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.rd_req),
        .req_addr(bus.rd_addr),
        .req_len (bus.rd_len),
        .ready   (bus.rready),
        .gnt     (bus.rd_gnt),
        .own     (bus.rd_own),
        .start   (bus.rstart),
        .addr    (bus.raddr),
        .len     (bus.rdata_len),
        .timeout (bus.rd_timeout)
    );

    // Data only flows for the current owner; traffic from anyone else is dropped.
    assign bus.wdata_vld = |(bus.wr_dvld & bus.wr_own);
    assign bus.wdata     = bus.wr_own[0] ? bus.wr_data[DATA_WIDTH-1:0] :
                           bus.wr_own[1] ? bus.wr_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign bus.rd_dvld   = {2{bus.rdata_vld}} & bus.rd_own;
    assign bus.rd_data   = bus.rdata;
endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Self-checking bench for ddr_cmd_arb: directed scenarios plus randomized traffic against
// a transaction-level model that tracks each path by owner and cycles since the start pulse.
module tb_ddr_cmd_arb;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int DW = 64;
    localparam int TO = 8;
`ifdef DDR_ARB_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ddr_cmd_arb_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

    ddr_cmd_arb #(
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model state per path (0 = write, 1 = read); age counts cycles since the start pulse, 0 = idle.
    int             m_age   [2];
    int             m_owner [2];
    int             m_last  [2];
    bit             m_to    [2];
    logic [1:0]     m_gnt   [2];
    bit             m_start [2];
    logic [AW-1:0]  m_addr  [2];
    logic [LW-1:0]  m_len   [2];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] own_of(input int o);
        return (o < 0) ? 2'b00 : ((o == 1) ? 2'b10 : 2'b01);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_age[p]   = 0;
            m_owner[p] = -1;
            m_last[p]  = 1;
            m_to[p]    = 1'b0;
            m_gnt[p]   = 2'b00;
            m_start[p] = 1'b0;
            m_addr[p]  = '0;
            m_len[p]   = '0;
        end
    endtask

    task automatic model_step(input int p, input logic [1:0] req, input logic [2*AW-1:0] addrs,
                              input logic [2*LW-1:0] lens, input logic ready);
        logic e0, e1;
        int   win;
        m_gnt[p]   = 2'b00;
        m_start[p] = 1'b0;
        if (m_age[p] == 0) begin
            e0  = req[0] && (lens[LW-1:0] == '0 || ready);
            e1  = req[1] && (lens[2*LW-1:LW] == '0 || ready);
            win = -1;
            if (e0 && e1) win = 1 - m_last[p];
            else if (e0) win = 0;
            else if (e1) win = 1;
            if (win >= 0) begin
                m_gnt[p][win] = 1'b1;
                m_last[p]     = win;
                if (lens[win*LW +: LW] != '0) begin
                    m_start[p] = 1'b1;
                    m_owner[p] = win;
                    m_age[p]   = 1;
                    m_addr[p]  = addrs[win*AW +: AW];
                    m_len[p]   = lens[win*LW +: LW];
                end
            end
        end else if (m_age[p] >= 4 && ready) begin
            m_age[p]   = 0;
            m_owner[p] = -1;
        end else if (TEN && m_age[p] >= 2 && m_age[p] - 1 >= TO) begin
            m_age[p]   = 0;
            m_owner[p] = -1;
            m_to[p]    = 1'b1;
        end else begin
            m_age[p]++;
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] exp_wdata;
        exp_wdata = (m_owner[0] >= 0) ? bus.wr_data[m_owner[0]*DW +: DW] : '0;
        checkOutput("wr_gnt",     bus.wr_gnt,     m_gnt[0]);
        checkOutput("wr_own",     bus.wr_own,     own_of(m_owner[0]));
        checkOutput("wstart",     bus.wstart,     m_start[0]);
        checkOutput("waddr",      bus.waddr,      m_addr[0]);
        checkOutput("wdata_len",  bus.wdata_len,  m_len[0]);
        checkOutput("wdata_vld",  bus.wdata_vld,  (m_owner[0] >= 0) && bus.wr_dvld[m_owner[0]]);
        checkOutput("wdata",      bus.wdata,      exp_wdata);
        checkOutput("rd_gnt",     bus.rd_gnt,     m_gnt[1]);
        checkOutput("rd_own",     bus.rd_own,     own_of(m_owner[1]));
        checkOutput("rstart",     bus.rstart,     m_start[1]);
        checkOutput("raddr",      bus.raddr,      m_addr[1]);
        checkOutput("rdata_len",  bus.rdata_len,  m_len[1]);
        checkOutput("rd_dvld",    bus.rd_dvld,    bus.rdata_vld ? own_of(m_owner[1]) : 2'b00);
        checkOutput("rd_data",    bus.rd_data,    bus.rdata);
        checkOutput("wr_timeout", bus.wr_timeout, m_to[0]);
        checkOutput("rd_timeout", bus.rd_timeout, m_to[1]);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0, bus.wr_req, bus.wr_addr, bus.wr_len, bus.wready);
                model_step(1, bus.rd_req, bus.rd_addr, bus.rd_len, bus.rready);
            end
            #1;
            compare_all();
        end
    end

    task automatic clear_inputs();
        bus.wr_req = '0; bus.wr_addr = '0; bus.wr_len = '0; bus.wr_dvld = '0; bus.wr_data = '0;
        bus.rd_req = '0; bus.rd_addr = '0; bus.rd_len = '0;
        bus.wready = 1'b0; bus.rready = 1'b0; bus.rdata_vld = 1'b0; bus.rdata = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        cycle();
        checkOutput("rst_wr_own",  bus.wr_own,     2'b00);
        checkOutput("rst_rd_own",  bus.rd_own,     2'b00);
        checkOutput("rst_wstart",  bus.wstart,     1'b0);
        checkOutput("rst_waddr",   bus.waddr,      32'h0);
        checkOutput("rst_rlen",    bus.rdata_len,  16'h0);
        checkOutput("rst_wr_to",   bus.wr_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One requester side: a granted or idle requester picks fresh values, a waiting one holds.
    task automatic drive_side(input logic [1:0] gnt, inout logic [1:0] req,
                              inout logic [2*AW-1:0] a, inout logic [2*LW-1:0] l);
        for (int i = 0; i < 2; i++) begin
            if (!req[i] || gnt[i]) begin
                req[i]         = ($urandom_range(0, 9) < 4);
                a[i*AW +: AW]  = $urandom;
                l[i*LW +: LW]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 300));
            end
        end
    endtask

    task automatic applyStimulus();
        logic [1:0]      req;
        logic [2*AW-1:0] a;
        logic [2*LW-1:0] l;
        req = bus.wr_req; a = bus.wr_addr; l = bus.wr_len;
        drive_side(bus.wr_gnt, req, a, l);
        bus.wr_req = req; bus.wr_addr = a; bus.wr_len = l;
        req = bus.rd_req; a = bus.rd_addr; l = bus.rd_len;
        drive_side(bus.rd_gnt, req, a, l);
        bus.rd_req = req; bus.rd_addr = a; bus.rd_len = l;
        bus.wready    = ($urandom_range(0, 3) != 0);
        bus.rready    = ($urandom_range(0, 3) != 0);
        bus.wr_dvld   = 2'($urandom);
        bus.wr_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.rdata_vld = $urandom_range(0, 1);
        bus.rdata     = {$urandom, $urandom};
    endtask

    initial begin
        logic [1:0] exp_order [3];
        int cyc, prev, waited, starts;
        exp_order = '{2'b01, 2'b10, 2'b01};
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Single write with immediate engine ready.
        @(negedge clk);
        bus.wr_req = 2'b01; bus.wr_addr[AW-1:0] = 32'h1000; bus.wr_len[LW-1:0] = 16'd16; bus.wready = 1'b1;
        cycle();
        checkOutput("single_wstart", bus.wstart,    1'b1);
        checkOutput("single_gnt",    bus.wr_gnt,    2'b01);
        checkOutput("single_waddr",  bus.waddr,     32'h1000);
        checkOutput("single_len",    bus.wdata_len, 16'd16);
        @(negedge clk);
        bus.wr_req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("single_own_held", bus.wr_own, 2'b01);
        end
        cycle();
        checkOutput("single_own_clr", bus.wr_own, 2'b00);

        // Contention: both write requesters hold req across three transfers.
        do_reset();
        @(negedge clk);
        bus.wr_req = 2'b11; bus.wr_addr = {32'hB000, 32'hA000}; bus.wr_len = {16'd8, 16'd8}; bus.wready = 1'b1;
        cyc = 0; prev = -1;
        for (int k = 0; k < 3; k++) begin
            waited = 0;
            do begin
                cycle();
                cyc++;
                waited++;
            end while (!bus.wstart && waited < 20);
            if (!bus.wstart) begin
                checkOutput("contend_start_seen", 1'b0, 1'b1);
            end else begin
                checkOutput("contend_gnt", bus.wr_gnt, exp_order[k]);
                if (prev >= 0) checkOutput("contend_gap", 64'(cyc - prev), 64'd5);
                prev = cyc;
            end
        end
        @(negedge clk);
        bus.wr_req = 2'b00;

        // Concurrent write by requester 0 and read by requester 1.
        do_reset();
        @(negedge clk);
        bus.wr_req = 2'b01; bus.wr_len = {16'd0, 16'd4}; bus.wready = 1'b1;
        bus.rd_req = 2'b10; bus.rd_len = {16'd6, 16'd0}; bus.rready = 1'b1;
        cycle();
        checkOutput("conc_wstart", bus.wstart, 1'b1);
        checkOutput("conc_rstart", bus.rstart, 1'b1);
        @(negedge clk);
        bus.wr_req = 2'b00; bus.rd_req = 2'b00;
        bus.rdata_vld = 1'b1; bus.rdata = 64'h0123_4567_89AB_CDEF;
        bus.wr_dvld = 2'b01; bus.wr_data = {64'hDEAD_0000_0000_0001, 64'h5555_AAAA_1234_5678};
        cycle();
        checkOutput("conc_rd_dvld", bus.rd_dvld,   2'b10);
        checkOutput("conc_rd_data", bus.rd_data,   64'h0123_4567_89AB_CDEF);
        checkOutput("conc_wdata",   bus.wdata,     64'h5555_AAAA_1234_5678);
        checkOutput("conc_wvld",    bus.wdata_vld, 1'b1);
        @(negedge clk);
        bus.rdata_vld = 1'b0; bus.wr_dvld = 2'b10;
        cycle();
        checkOutput("conc_rd_dvld_off", bus.rd_dvld,   2'b00);
        checkOutput("conc_wvld_nonown", bus.wdata_vld, 1'b0);

        // Zero-length read request.
        do_reset();
        @(negedge clk);
        bus.rd_req = 2'b10; bus.rd_len = {16'd0, 16'd0}; bus.rready = 1'b1;
        cycle();
        checkOutput("zero_gnt",    bus.rd_gnt, 2'b10);
        checkOutput("zero_rstart", bus.rstart, 1'b0);
        checkOutput("zero_own",    bus.rd_own, 2'b00);
        @(negedge clk);
        bus.rd_req = 2'b00;
        cycle();
        checkOutput("zero_gnt_off", bus.rd_gnt, 2'b00);

        // Reset in the middle of a transfer.
        do_reset();
        @(negedge clk);
        bus.wr_req = 2'b01; bus.wr_len = {16'd0, 16'd5}; bus.wready = 1'b1;
        cycle();
        @(negedge clk);
        bus.wr_req = 2'b00;
        rst = 1'b1;
        #1;
        checkOutput("midrst_own", bus.wr_own, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.wstart) starts++;
        end
        checkOutput("midrst_no_start", 64'(starts), 64'd0);

        // Engine never becomes ready after the start pulse.
        do_reset();
        @(negedge clk);
        bus.wr_req = 2'b01; bus.wr_len = {16'd0, 16'd4}; bus.wready = 1'b1;
        cycle();
        @(negedge clk);
        bus.wr_req = 2'b00; bus.wready = 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) cycle();
        checkOutput("wd_before",     bus.wr_timeout, 1'b0);
        checkOutput("wd_own_before", bus.wr_own,     2'b01);
        cycle();
        checkOutput("wd_flag",       bus.wr_timeout, 1'b1);
        checkOutput("wd_own_clr",    bus.wr_own,     2'b00);
        do_reset();
        checkOutput("wd_flag_rst",   bus.wr_timeout, 1'b0);
`else
        for (int i = 0; i < 12; i++) cycle();
        checkOutput("hang_own",  bus.wr_own,     2'b01);
        checkOutput("hang_flag", bus.wr_timeout, 1'b0);
        do_reset();
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
